// File: rtl/bram_stream_reader.sv
// Purpose : read-side master for a 1-cycle-latency synchronous BRAM; streams a
//           contiguous, wrapping address range out on a valid/ready port.
// Latency : start in cycle 0 -> first address in cycle 1 -> first beat in cycle 3.
// Backpr. : reads are credit-limited to the 4-entry prefetch FIFO, so out_ready
//           may stall indefinitely without losing or reordering data.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, start_addr,  command strobe (sampled only in IDLE), first address,
//   length              word count 0..2^ADDR_W (larger values saturate)
//   busy, done          busy while streaming; one-cycle done pulse at the end
//   mem_read_addr/data  BRAM read port (data valid one cycle after address)
//   out_data/valid/     output stream; out_last marks the final beat
//   ready/last
module bram_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W:0]   len_sat;
    logic [ADDR_W-1:0] rd_addr;      // next address to put on the BRAM port
    logic [ADDR_W:0]   issue_left;   // reads still to be issued
    logic [ADDR_W:0]   beat_left;    // beats still to be handshaked

    // rd_v1: an address is on the BRAM port this cycle.
    // rd_v2: the BRAM data for last cycle's address is valid this cycle.
    logic rd_v1, rd_v2;

    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        fifo_count;
    logic [2:0]        occupancy;
    logic              credit_ok;

    logic issue;     // an address is driven onto the BRAM port next cycle
    logic accept;
    logic push, pop;

    assign len_sat = (length > DEPTH) ? DEPTH : length;

    // The issue decision is registered into mem_read_addr, so it is taken one
    // cycle ahead. Counting the read currently on the port (rd_v1) and the one
    // being written (rd_v2) keeps FIFO + in-flight at or below 4 without a
    // combinational path from out_ready.
    assign occupancy = fifo_count + {2'b00, rd_v1} + {2'b00, rd_v2};
    assign credit_ok = (occupancy < 3'd4);

    assign push      = rd_v2;
    assign out_valid = (fifo_count != 3'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign out_last  = out_valid && (beat_left == {{ADDR_W{1'b0}}, 1'b1});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_sat != '0) begin
                        accept    = 1'b1;
                        issue     = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if ((issue_left != '0) && credit_ok) begin
                    issue = 1'b1;
                end
                if (pop && (beat_left == {{ADDR_W{1'b0}}, 1'b1})) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_read_addr <= '0;
            rd_addr       <= '0;
            issue_left    <= '0;
            beat_left     <= '0;
            rd_v1         <= 1'b0;
            rd_v2         <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            rd_v1 <= issue;
            rd_v2 <= rd_v1;

            if (accept) begin
                // The first read goes out with the acceptance, so the walking
                // address and issue count start one step ahead.
                mem_read_addr <= start_addr;
                rd_addr       <= start_addr + ADDR_W'(1);
                issue_left    <= len_sat - (ADDR_W+1)'(1);
                beat_left     <= len_sat;
            end else begin
                if (issue) begin
                    mem_read_addr <= rd_addr;
                    rd_addr       <= rd_addr + ADDR_W'(1);
                    issue_left    <= issue_left - (ADDR_W+1)'(1);
                end
                if (pop) begin
                    beat_left <= beat_left - (ADDR_W+1)'(1);
                end
            end

            if (push) begin
                fifo_mem[wr_ptr] <= mem_read_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 3'd1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] start_addr = '0;
    logic [4:0] length = '0;
    logic       busy, done;
    logic [3:0] mem_read_addr;
    logic [7:0] mem_read_data = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;

    bram_stream_reader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_addr   (start_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    // BRAM model: registered read, no enable.
    logic [7:0] mem [16];
    always @(posedge clk) mem_read_data <= mem[mem_read_addr];

    int checks = 0;
    int failures = 0;

    // Results of the most recent run_collect.
    logic [7:0] got [$];
    int         last_pos, last_cnt, done_cyc, first_vld, stable_err, max_occ, timeout;
    int         busy_seen;
    logic [3:0] addr_c1;

    logic [15:0] rdy_pat = 16'h9191;

    // Issue a start in the next cycle (cycle 0) and record the stream until
    // done is seen. mode 1 applies the out_ready pattern; restart_cyc pulses a
    // second start with different parameters in that cycle.
    task automatic run_collect(input logic [3:0] a, input logic [4:0] l,
                               input int mode, input int restart_cyc);
        int issued, popped, l_eff, occ;
        logic pv, pr, pl;
        logic [7:0] pd;
        logic [3:0] pa;
        got.delete();
        last_pos = -1; last_cnt = 0; done_cyc = -1; first_vld = -1;
        stable_err = 0; max_occ = 0; timeout = 0; busy_seen = 0; addr_c1 = '0;
        issued = 0; popped = 0; pv = 0; pr = 0; pl = 0; pd = '0; pa = '0;
        l_eff = (l > 5'd16) ? 16 : int'(l);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; length = l; out_ready = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            start = (c == restart_cyc);
            if (c == restart_cyc) begin
                start_addr = 4'd9;
                length = 5'd2;
            end
            if (c == 1) addr_c1 = mem_read_addr;
            if (busy === 1'b1) busy_seen++;
            if (busy === 1'b1 && issued < l_eff && (c == 1 || mem_read_addr !== pa)) issued++;
            pa = mem_read_addr;
            occ = issued - popped;
            if (occ > max_occ) max_occ = occ;
            if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl))
                stable_err++;
            out_ready = (mode == 0) ? 1'b1 : rdy_pat[c % 16];
            if (out_valid === 1'b1 && first_vld < 0) first_vld = c;
            if (out_valid === 1'b1 && out_ready) begin
                got.push_back(out_data);
                if (out_last === 1'b1) begin
                    last_pos = got.size() - 1;
                    last_cnt++;
                end
                popped++;
            end
            pv = (out_valid === 1'b1); pr = out_ready; pd = out_data; pl = out_last;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        if (done_cyc < 0) timeout = 1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", out_last); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", out_data); end
        checks++; if (mem_read_addr !== 4'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", mem_read_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        run_collect(4'd2, 5'd4, 0, -1);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL basic_timeout: done not seen"); end
        checks++; if (addr_c1 !== 4'd2) begin failures++; $display("FAIL basic_addr_c1: got %0d expected 2", addr_c1); end
        checks++; if (first_vld !== 3) begin failures++; $display("FAIL basic_first_valid: got cycle %0d expected 3", first_vld); end
        checks++; if (got.size() !== 4) begin failures++; $display("FAIL basic_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'hA2 + 8'(i);
            checks++; if (got[i] !== exp) begin failures++; $display("FAIL basic_beat%0d: got %h expected %h", i, got[i], exp); end
        end
        checks++; if (last_pos !== 3 || last_cnt !== 1) begin failures++; $display("FAIL basic_last: got pos %0d cnt %0d expected pos 3 cnt 1", last_pos, last_cnt); end
        checks++; if (done_cyc !== 7) begin failures++; $display("FAIL basic_done_cycle: got %0d expected 7", done_cyc); end
        checks++; if (busy_seen !== 6) begin failures++; $display("FAIL basic_busy_cycles: got %0d expected 6", busy_seen); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [4];
        exp[0] = 8'hAE; exp[1] = 8'hAF; exp[2] = 8'hA0; exp[3] = 8'hA1;
        run_collect(4'd14, 5'd4, 0, -1);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL wrap_timeout: done not seen"); end
        checks++; if (got.size() !== 4) begin failures++; $display("FAIL wrap_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL wrap_beat%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        checks++; if (last_pos !== 3 || last_cnt !== 1) begin failures++; $display("FAIL wrap_last: got pos %0d cnt %0d expected pos 3 cnt 1", last_pos, last_cnt); end
    endtask

    task automatic test_backpressure();
        int bad;
        run_collect(4'd0, 5'd16, 1, -1);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL bp_timeout: done not seen"); end
        checks++; if (got.size() !== 16) begin failures++; $display("FAIL bp_count: got %0d expected 16", got.size()); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (got[i] !== 8'hA0 + 8'(i)) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_order: got %0d wrong beats expected 0", bad); end
        checks++; if (stable_err !== 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_err); end
        checks++; if (max_occ !== 4) begin failures++; $display("FAIL bp_credit: got max outstanding %0d expected 4", max_occ); end
        checks++; if (last_pos !== 15 || last_cnt !== 1) begin failures++; $display("FAIL bp_last: got pos %0d cnt %0d expected pos 15 cnt 1", last_pos, last_cnt); end
    endtask

    task automatic test_length_edges();
        int bad;
        run_collect(4'd3, 5'd0, 0, -1);
        checks++; if (done_cyc !== 1) begin failures++; $display("FAIL len0_done_cycle: got %0d expected 1", done_cyc); end
        checks++; if (got.size() !== 0 || first_vld !== -1) begin failures++; $display("FAIL len0_beats: got %0d beats expected 0", got.size()); end
        checks++; if (busy_seen !== 0) begin failures++; $display("FAIL len0_busy: got %0d busy cycles expected 0", busy_seen); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL len0_pulse: got done %b expected 0", done); end

        run_collect(4'd5, 5'd31, 0, -1);
        checks++; if (timeout !== 0) begin failures++; $display("FAIL sat_timeout: done not seen"); end
        checks++; if (got.size() !== 16) begin failures++; $display("FAIL sat_count: got %0d expected 16", got.size()); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (got[i] !== 8'hA0 + 8'((5 + i) % 16)) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL sat_order: got %0d wrong beats expected 0", bad); end
        checks++; if (done_cyc !== 19) begin failures++; $display("FAIL sat_done_cycle: got %0d expected 19", done_cyc); end
    endtask

    task automatic test_start_ignored();
        int bad;
        run_collect(4'd4, 5'd6, 0, 3);
        checks++; if (got.size() !== 6) begin failures++; $display("FAIL ign_count: got %0d expected 6", got.size()); end
        bad = 0;
        for (int i = 0; i < 6; i++) if (got[i] !== 8'hA4 + 8'(i)) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL ign_order: got %0d wrong beats expected 0", bad); end
        checks++; if (done_cyc !== 9) begin failures++; $display("FAIL ign_done_cycle: got %0d expected 9", done_cyc); end
    endtask

    // Starts in the IDLE cycle immediately after the previous done pulse.
    task automatic test_back_to_back();
        run_collect(4'd10, 5'd3, 0, -1);
        checks++; if (first_vld !== 3) begin failures++; $display("FAIL b2b_first_valid: got cycle %0d expected 3", first_vld); end
        checks++; if (got.size() !== 3 || got[0] !== 8'hAA || got[1] !== 8'hAB || got[2] !== 8'hAC)
            begin failures++; $display("FAIL b2b_beats: got %0d beats first %h expected 3 beats AA AB AC", got.size(), got[0]); end
        checks++; if (done_cyc !== 6) begin failures++; $display("FAIL b2b_done_cycle: got %0d expected 6", done_cyc); end
    endtask

    task automatic test_reset_mid();
        int beats;
        logic hit;
        beats = 0; hit = 0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 4'd0; length = 5'd8; out_ready = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (out_valid === 1'b1 && out_ready) beats++;
            if (beats == 3) begin
                rst_n = 1'b0;
                hit = 1;
                break;
            end
        end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rstmid_timeout: 3 beats not seen"); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin failures++; $display("FAIL rstmid_state: got valid %b busy %b done %b expected 0 0 0", out_valid, busy, done); end
        rst_n = 1'b1;
        run_collect(4'd3, 5'd2, 0, -1);
        checks++; if (got.size() !== 2 || got[0] !== 8'hA3 || got[1] !== 8'hA4)
            begin failures++; $display("FAIL rstmid_new: got %0d beats first %h expected 2 beats A3 A4", got.size(), got[0]); end
        checks++; if (done_cyc !== 5) begin failures++; $display("FAIL rstmid_done_cycle: got %0d expected 5", done_cyc); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_length_edges();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
